// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit multi-cycle core.
// Holds the opcode values, the control FSM state encodings, the PC and ALU
// operand-B source encodings, and the bit positions inside the flag register.
// Both the control unit and the ALU import this package, so they use the same
// opcode numbering.
package cpu_pkg;

  // Instruction opcodes. Values 9 and above are undefined.
  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ANDI = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_J    = 6'd8;

  // Control FSM states. The encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  // Next-PC source select.
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target

  // ALU operand-B source select.
  localparam logic ALU_SRC_RT  = 1'b0;  // register rt
  localparam logic ALU_SRC_IMM = 1'b1;  // sign-extended immediate

  // Bit positions inside the {carry, zero, negative, overflow} flag register.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory bus between the control unit and the memory.
//   mem_ready : memory completes the current read or write this cycle
//   mem_read  : read request
//   mem_write : write request
//   iord      : address select, 0 = PC, 1 = ALU result register
// The control unit connects through the master modport, the memory side
// through the slave modport.
interface multicycle_control_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic iord;

  modport master (
    input  mem_ready,
    output mem_read,
    output mem_write,
    output iord
  );

  modport slave (
    output mem_ready,
    input  mem_read,
    input  mem_write,
    input  iord
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state timer for memory accesses.
// Counts the cycles a memory access has been waiting and raises bus_error
// when the count reaches MEM_TIMEOUT while mem_ready is still low.
//   clk, reset : clock and synchronous active-high reset
//   active     : the FSM is in a memory-waiting state (FETCH or MEM)
//   mem_ready  : memory completes the access this cycle
//   bus_error  : one-cycle timeout pulse; the FSM abandons the access on it
// MEM_TIMEOUT = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic bus_error
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout;

  // A ready in the timeout cycle wins: the access completes normally.
  always_comb begin
    timeout = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      timeout = active && !mem_ready && (cnt_q == CNT_LIMIT);
    end
  end

  // The count only survives while the FSM keeps waiting in the same state.
  // Every exit from FETCH/MEM happens on a ready or a timeout, and both
  // clear the count, so it always starts at zero on entry.
  always_comb begin
    cnt_d = '0;
    if (active && !mem_ready && !timeout) begin
      // Saturate so a disabled timeout never wraps.
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus_error = timeout && !reset;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 32-bit core.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) around the
// shared combinational ALU and drives the ALU opcode, datapath mux selects
// and register/memory/PC strobes. Holds the architectural flag register.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   opcode            : instruction opcode, stable from DECODE onward
//   alu_zero/carry/negative/overflow : combinational ALU flags
//   bus               : memory bus (mem_ready in; mem_read, mem_write, iord out)
//   alu_op, alu_src_b : ALU operation and operand-B select
//   pc_src, pc_write  : next-PC select and PC load strobe
//   ir_write          : instruction register load strobe
//   reg_write, reg_dst, wb_src : register file write strobe, dest and source
//   flags             : registered {carry, zero, negative, overflow}
//   illegal_op        : one-cycle pulse on an undefined opcode
//   bus_error         : one-cycle pulse on a memory timeout
//   state_dbg         : current state encoding
// Outputs are decoded from state and opcode; the FETCH strobes and the MEM
// exit are additionally qualified by mem_ready.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int OPCODE_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                alu_carry,
  input  logic                alu_negative,
  input  logic                alu_overflow,
  multicycle_control_if.master bus,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                alu_src_b,
  output logic [1:0]          pc_src,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                wb_src,
  output logic [3:0]          flags,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [2:0]          state_dbg
);

  state_e state_q;
  state_e state_d;
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  logic is_arith;   // AND, ADD, SUB, ANDI, ADDI
  logic is_rtype;   // AND, ADD, SUB: result goes to rd
  logic is_imm;     // instructions that take the sign-extended immediate
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_legal;

  logic mem_wait;   // FSM is in a state that waits on mem_ready
  logic timeout;

  logic mem_read_o;
  logic mem_write_o;
  logic iord_o;

  // ALU operation used in EXECUTE: arithmetic passes its opcode through,
  // loads/stores compute the address with ADD, BEQ compares with SUB.
  function automatic logic [OPCODE_W-1:0] exec_alu_op(input logic [OPCODE_W-1:0] op);
    if (op <= OPCODE_W'(OP_ADDI)) begin
      return op;
    end else if (op == OPCODE_W'(OP_BEQ)) begin
      return OPCODE_W'(OP_SUB);
    end else begin
      return OPCODE_W'(OP_ADD);
    end
  endfunction

  always_comb begin
    is_arith = (opcode <= OPCODE_W'(OP_ADDI));
    is_rtype = (opcode <= OPCODE_W'(OP_SUB));
    is_lw    = (opcode == OPCODE_W'(OP_LW));
    is_sw    = (opcode == OPCODE_W'(OP_SW));
    is_beq   = (opcode == OPCODE_W'(OP_BEQ));
    is_j     = (opcode == OPCODE_W'(OP_J));
    is_legal = (opcode <= OPCODE_W'(OP_J));
    is_imm   = (opcode == OPCODE_W'(OP_ANDI)) || (opcode == OPCODE_W'(OP_ADDI)) ||
               is_lw || is_sw;
  end

  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .active   (mem_wait),
    .mem_ready(bus.mem_ready),
    .bus_error(timeout)
  );

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Flags are architectural state: only arithmetic instructions update them,
  // on the EXECUTE edge. BEQ uses the ALU but leaves them alone.
  always_comb begin
    flags_d = flags_q;
    if ((state_q == ST_EXECUTE) && is_arith) begin
      flags_d[FLAG_C] = alu_carry;
      flags_d[FLAG_Z] = alu_zero;
      flags_d[FLAG_N] = alu_negative;
      flags_d[FLAG_V] = alu_overflow;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        // A timeout restarts the fetch; staying put has the same encoding,
        // the timer clears itself on the timeout cycle.
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_j || !is_legal) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_arith) begin
          state_d = ST_WRITEBACK;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = is_lw ? ST_WRITEBACK : ST_FETCH;
        end else if (timeout) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode. Everything is forced quiet while reset is high so an
  // abandoned instruction produces no writes.
  always_comb begin
    alu_op      = '0;
    alu_src_b   = ALU_SRC_RT;
    pc_src      = PC_SRC_SEQ;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord_o      = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    wb_src      = 1'b0;
    illegal_op  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_read_o = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_SEQ;
          end
        end
        ST_DECODE: begin
          if (is_j) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end else if (!is_legal) begin
            illegal_op = 1'b1;
          end
        end
        ST_EXECUTE: begin
          alu_op    = exec_alu_op(opcode);
          alu_src_b = is_imm ? ALU_SRC_IMM : ALU_SRC_RT;
          if (is_beq) begin
            pc_src   = PC_SRC_BRANCH;
            pc_write = alu_zero;
          end
        end
        ST_MEM: begin
          // Keep the address computation stable while the access waits.
          iord_o      = 1'b1;
          alu_op      = OPCODE_W'(OP_ADD);
          alu_src_b   = ALU_SRC_IMM;
          mem_read_o  = is_lw;
          mem_write_o = is_sw;
        end
        ST_WRITEBACK: begin
          reg_write = 1'b1;
          reg_dst   = is_rtype;
          wb_src    = is_lw;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_read  = mem_read_o;
  assign bus.mem_write = mem_write_o;
  assign bus.iord      = iord_o;
  assign flags         = flags_q;
  assign bus_error     = timeout;
  assign state_dbg     = state_q;

endmodule
